// File: rtl/tag_ram_ctrl_pkg.sv
// Shared types and entry field helpers for the tag RAM controller.
package tag_ram_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int DWIDTH_DEF = 7;
  localparam int VBIT_POS   = DWIDTH_DEF - 1;
  localparam int ENTRY_MAX  = 32;

  localparam int REQ_LK = 0;
  localparam int REQ_UP = 1;

  // Entries are handled zero-extended to ENTRY_MAX bits so one helper serves every DWIDTH.
  function automatic logic entry_vbit(input logic [ENTRY_MAX-1:0] entry, input int dwidth);
    logic [ENTRY_MAX-1:0] shifted;
    shifted = entry >> (dwidth - 1);
    return shifted[0];
  endfunction

  function automatic logic [ENTRY_MAX-1:0] entry_tag(input logic [ENTRY_MAX-1:0] entry,
                                                     input int dwidth);
    logic [ENTRY_MAX-1:0] mask;
    mask = (ENTRY_MAX'(1) << (dwidth - 1)) - ENTRY_MAX'(1);
    return entry & mask;
  endfunction

endpackage

// File: rtl/tag_ram_ctrl_arb.sv
// Two-requester arbiter (bit 0 lookup, bit 1 update).
// TAG_CTRL_RR_ARB_EN selects round-robin; otherwise lookup has fixed priority.
module tag_arb2
  import tag_ram_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef TAG_CTRL_RR_ARB_EN
  // ptr = 1 means the update side wins the next contended cycle
  logic ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (&req) begin
      ptr <= ~ptr;
    end
  end

  always_comb begin
    grant = req;
    if (&req) begin
      grant = ptr ? (2'b1 << REQ_UP) : (2'b1 << REQ_LK);
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clock ^ reset;

  always_comb begin
    grant = req;
    if (&req) begin
      grant = 2'b1 << REQ_LK;
    end
  end
`endif

endmodule

// File: rtl/tag_ram_ctrl.sv
// Tag RAM controller: lookup/update sharing of a sync-read RAM plus a flush sequencer.
// Arbitration policy chosen by TAG_CTRL_RR_ARB_EN (round-robin) or fixed lookup priority.
module tag_ram_ctrl
  import tag_ram_ctrl_pkg::*;
#(
  parameter  int AWIDTH = 3,
  parameter  int DWIDTH = VBIT_POS + 1,
  localparam int TWIDTH = DWIDTH - 1,
  localparam int DEPTH  = 1 << AWIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lk_valid,
  output logic              lk_ready,
  input  logic [AWIDTH-1:0] lk_index,
  input  logic [TWIDTH-1:0] lk_tag,
  output logic              lk_resp_valid,
  output logic              lk_hit,
  output logic [TWIDTH-1:0] lk_resp_tag,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [AWIDTH-1:0] up_index,
  input  logic [TWIDTH-1:0] up_tag,
  input  logic              up_vbit,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              flush_done,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  state_t              state;
  state_t              state_next;
  logic [AWIDTH-1:0]   flush_cnt;
  logic                flush_last;
  logic [1:0]          arb_req;
  logic [1:0]          grant;
  logic                lk_p1;
  logic [TWIDTH-1:0]   lk_tag_p1;
  logic [ENTRY_MAX-1:0] dout_ext;
  logic                dout_vbit;
  logic [TWIDTH-1:0]   dout_tag;

  assign flush_last = (flush_cnt == AWIDTH'(DEPTH - 1));
  assign flush_busy = (state == FLUSH);

  // Requests only compete in IDLE with no flush pending and outside reset.
  always_comb begin
    arb_req = 2'b00;
    if ((state == IDLE) && !flush_req && !reset) begin
      arb_req = {up_valid, lk_valid};
    end
  end

  tag_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   (arb_req),
    .grant (grant)
  );

  assign lk_ready = grant[REQ_LK];
  assign up_ready = grant[REQ_UP];

  always_comb begin
    state_next = state;
    ram_addr   = '0;
    ram_din    = '0;
    ram_we     = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_next = FLUSH;
        end else if (grant[REQ_UP]) begin
          ram_addr = up_index;
          ram_din  = {up_vbit, up_tag};
          ram_we   = 1'b1;
        end else if (grant[REQ_LK]) begin
          ram_addr = lk_index;
        end
      end
      FLUSH: begin
        ram_addr = flush_cnt;
        // a reset landing mid-flush must not clear the current entry
        ram_we   = !reset;
        if (flush_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      flush_cnt  <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      flush_done <= (state == FLUSH) && flush_last;
      if (state == FLUSH) begin
        flush_cnt <= flush_cnt + AWIDTH'(1);
      end else begin
        flush_cnt <= '0;
      end
    end
  end

  assign dout_ext  = ENTRY_MAX'(ram_dout);
  assign dout_vbit = entry_vbit(dout_ext, DWIDTH);
  assign dout_tag  = TWIDTH'(entry_tag(dout_ext, DWIDTH));

  // Stage 1 waits for the RAM read; stage 2 registers the compare.
  always_ff @(posedge clock) begin
    if (reset) begin
      lk_p1         <= 1'b0;
      lk_tag_p1     <= '0;
      lk_resp_valid <= 1'b0;
      lk_hit        <= 1'b0;
      lk_resp_tag   <= '0;
    end else begin
      lk_p1         <= grant[REQ_LK];
      lk_tag_p1     <= lk_tag;
      lk_resp_valid <= lk_p1;
      if (lk_p1) begin
        lk_hit      <= dout_vbit && (dout_tag == lk_tag_p1);
        lk_resp_tag <= dout_tag;
      end
    end
  end

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Self-checking bench for tag_ram_ctrl with a behavioural tag store and arbiter model.
// Honours TAG_CTRL_RR_ARB_EN the same way as the design.
module tb_tag_ram_ctrl;

`ifdef TAG_CTRL_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       lk_valid, lk_ready, lk_resp_valid, lk_hit;
  logic [2:0] lk_index;
  logic [5:0] lk_tag, lk_resp_tag;
  logic       up_valid, up_ready, up_vbit;
  logic [2:0] up_index;
  logic [5:0] up_tag;
  logic       flush_req, flush_busy, flush_done;
  logic [2:0] ram_addr;
  logic [6:0] ram_din, ram_dout;
  logic       ram_we;

  logic       pre_we;
  logic [2:0] pre_addr;
  logic [6:0] pre_data;
  logic [6:0] mem [8];

  logic [6:0] model_mem [8];
  logic       model_ptr;
  int         errors;
  int         checks;

  typedef struct packed {
    int         due;
    logic       hit;
    logic [5:0] tag;
  } resp_t;

  always #5 clock = ~clock;

  tag_ram_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .lk_valid      (lk_valid),
    .lk_ready      (lk_ready),
    .lk_index      (lk_index),
    .lk_tag        (lk_tag),
    .lk_resp_valid (lk_resp_valid),
    .lk_hit        (lk_hit),
    .lk_resp_tag   (lk_resp_tag),
    .up_valid      (up_valid),
    .up_ready      (up_ready),
    .up_index      (up_index),
    .up_tag        (up_tag),
    .up_vbit       (up_vbit),
    .flush_req     (flush_req),
    .flush_busy    (flush_busy),
    .flush_done    (flush_done),
    .ram_addr      (ram_addr),
    .ram_din       (ram_din),
    .ram_we        (ram_we),
    .ram_dout      (ram_dout)
  );

  // Single-port read-first RAM with a bench-side preload port.
  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  function automatic logic model_hit(input logic [2:0] idx, input logic [5:0] tag);
    return model_mem[idx][6] && (model_mem[idx][5:0] == tag);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pre_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pre_addr = 3'(i);
      pre_data = 7'($urandom);
      model_mem[i] = pre_data;
      step();
    end
    pre_we = 1'b0;
    #1;
    checks++; if (lk_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got=%0b want=0", lk_resp_valid); end
    checks++; if (lk_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit got=%0b want=0", lk_hit); end
    checks++; if (lk_resp_tag !== 6'h0) begin errors++; $display("[TB] FAIL reset_resp_tag got=%0h want=0", lk_resp_tag); end
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush_busy got=%0b want=0", flush_busy); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush_done got=%0b want=0", flush_done); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_we got=%0b want=0", ram_we); end
    reset = 1'b0;
    model_ptr = 1'b0;
  endtask

  // Write-then-lookup back to back on index 5, covering hit, tag miss and invalid entry.
  task automatic test_update_lookup();
    bit         do_up [3] = '{1'b1, 1'b0, 1'b1};
    bit         vb    [3] = '{1'b1, 1'b1, 1'b0};
    logic [5:0] ltag  [3] = '{6'h2A, 6'h2B, 6'h2A};
    logic       exp_hit;
    logic [5:0] exp_tag;
    for (int s = 0; s < 3; s++) begin
      if (do_up[s]) begin
        up_valid = 1'b1; up_index = 3'd5; up_tag = 6'h2A; up_vbit = vb[s];
        #1;
        checks++; if (up_ready !== 1'b1) begin errors++; $display("[TB] FAIL upd_ready s=%0d got=%0b want=1", s, up_ready); end
        checks++; if (ram_we !== 1'b1) begin errors++; $display("[TB] FAIL upd_we s=%0d got=%0b want=1", s, ram_we); end
        checks++; if (ram_addr !== 3'd5) begin errors++; $display("[TB] FAIL upd_addr s=%0d got=%0d want=5", s, ram_addr); end
        checks++; if (ram_din !== {vb[s], 6'h2A}) begin errors++; $display("[TB] FAIL upd_din s=%0d got=%0h want=%0h", s, ram_din, {vb[s], 6'h2A}); end
        model_mem[5] = {vb[s], 6'h2A};
        step();
        up_valid = 1'b0;
      end
      lk_valid = 1'b1; lk_index = 3'd5; lk_tag = ltag[s];
      #1;
      checks++; if (lk_ready !== 1'b1) begin errors++; $display("[TB] FAIL lk_ready s=%0d got=%0b want=1", s, lk_ready); end
      checks++; if (ram_we !== 1'b0 || ram_addr !== 3'd5) begin errors++; $display("[TB] FAIL lk_ram_port s=%0d got=we%0b/a%0d want=we0/a5", s, ram_we, ram_addr); end
      exp_hit = model_hit(3'd5, ltag[s]);
      exp_tag = model_mem[5][5:0];
      step();
      lk_valid = 1'b0;
      checks++; if (lk_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL lk_c1_valid s=%0d got=%0b want=0", s, lk_resp_valid); end
      step();
      checks++; if (lk_resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL lk_c2_valid s=%0d got=%0b want=1", s, lk_resp_valid); end
      checks++; if (lk_hit !== exp_hit) begin errors++; $display("[TB] FAIL lk_hit s=%0d got=%0b want=%0b", s, lk_hit, exp_hit); end
      checks++; if (lk_resp_tag !== exp_tag) begin errors++; $display("[TB] FAIL lk_tag s=%0d got=%0h want=%0h", s, lk_resp_tag, exp_tag); end
    end
    step();
  endtask

  task automatic test_contention();
    logic exp_l;
    lk_valid = 1'b1; lk_index = 3'($urandom); lk_tag = 6'($urandom);
    up_valid = 1'b1; up_index = 3'($urandom); up_tag = 6'($urandom); up_vbit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_l = !RR || !model_ptr;
      checks++; if (lk_ready !== exp_l || up_ready !== !exp_l) begin errors++; $display("[TB] FAIL contend_grant i=%0d got=L%0b/U%0b want=L%0b/U%0b", i, lk_ready, up_ready, exp_l, !exp_l); end
      if (!exp_l) model_mem[up_index] = {up_vbit, up_tag};
      if (RR) model_ptr = !model_ptr;
      step();
    end
    lk_valid = 1'b0; up_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_write_after_read();
    logic       exp_hit;
    logic [5:0] exp_tag;
    lk_valid = 1'b1; lk_index = 3'd3; lk_tag = model_mem[3][5:0];
    exp_hit = model_hit(3'd3, lk_tag);
    exp_tag = model_mem[3][5:0];
    step();
    lk_valid = 1'b0;
    up_valid = 1'b1; up_index = 3'd3; up_tag = 6'h11; up_vbit = 1'b1;
    #1;
    checks++; if (up_ready !== 1'b1) begin errors++; $display("[TB] FAIL war_up_ready got=%0b want=1", up_ready); end
    model_mem[3] = {1'b1, 6'h11};
    step();
    up_valid = 1'b0;
    checks++; if (lk_resp_valid !== 1'b1 || lk_resp_tag !== exp_tag || lk_hit !== exp_hit) begin errors++; $display("[TB] FAIL war_old_data got=v%0b/h%0b/t%0h want=v1/h%0b/t%0h", lk_resp_valid, lk_hit, lk_resp_tag, exp_hit, exp_tag); end
    lk_valid = 1'b1; lk_index = 3'd3; lk_tag = 6'h11;
    exp_hit = model_hit(3'd3, 6'h11);
    exp_tag = model_mem[3][5:0];
    step();
    lk_valid = 1'b0;
    step();
    checks++; if (lk_resp_valid !== 1'b1 || lk_resp_tag !== exp_tag || lk_hit !== exp_hit) begin errors++; $display("[TB] FAIL war_new_data got=v%0b/h%0b/t%0h want=v1/h%0b/t%0h", lk_resp_valid, lk_hit, lk_resp_tag, exp_hit, exp_tag); end
    step();
  endtask

  // Random traffic with a response scoreboard; losers hold their request stable.
  task automatic test_random();
    resp_t q[$];
    resp_t r;
    logic  lk_pend, up_pend, exp_l, exp_u;
    lk_pend = 1'b0; up_pend = 1'b0;
    for (int cyc = 0; cyc < 203; cyc++) begin
      if (cyc >= 200) begin
        lk_valid = 1'b0; up_valid = 1'b0;
      end else begin
        if (!lk_pend) begin
          lk_valid = ($urandom_range(0, 2) != 0);
          lk_index = 3'($urandom);
          lk_tag   = $urandom_range(0, 1) ? model_mem[lk_index][5:0] : 6'($urandom);
        end
        if (!up_pend) begin
          up_valid = ($urandom_range(0, 2) == 0);
          up_index = 3'($urandom);
          up_tag   = 6'($urandom);
          up_vbit  = 1'($urandom);
        end
      end
      #1;
      exp_l = lk_valid && (!up_valid || !RR || !model_ptr);
      exp_u = up_valid && !exp_l;
      checks++; if (lk_ready !== exp_l || up_ready !== exp_u) begin errors++; $display("[TB] FAIL rand_grant cyc=%0d got=L%0b/U%0b want=L%0b/U%0b", cyc, lk_ready, up_ready, exp_l, exp_u); end
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        checks++; if (lk_resp_valid !== 1'b1 || lk_hit !== r.hit || lk_resp_tag !== r.tag) begin errors++; $display("[TB] FAIL rand_resp cyc=%0d got=v%0b/h%0b/t%0h want=v1/h%0b/t%0h", cyc, lk_resp_valid, lk_hit, lk_resp_tag, r.hit, r.tag); end
      end else begin
        checks++; if (lk_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rand_idle cyc=%0d got=%0b want=0", cyc, lk_resp_valid); end
      end
      if (exp_l) q.push_back('{cyc + 2, model_hit(lk_index, lk_tag), model_mem[lk_index][5:0]});
      if (exp_u) model_mem[up_index] = {up_vbit, up_tag};
      if (RR && lk_valid && up_valid) model_ptr = !model_ptr;
      lk_pend = lk_valid && !exp_l;
      up_pend = up_valid && !exp_u;
      step();
    end
  endtask

  task automatic test_flush();
    logic       exp_hit;
    logic [5:0] exp_tag;
    logic       eh [8];
    logic [5:0] et [8];
    lk_valid = 1'b1; up_valid = 1'b0; lk_index = 3'($urandom); lk_tag = model_mem[lk_index][5:0];
    exp_hit = model_hit(lk_index, lk_tag);
    exp_tag = model_mem[lk_index][5:0];
    #1;
    checks++; if (lk_ready !== 1'b1) begin errors++; $display("[TB] FAIL fl_pre_ready got=%0b want=1", lk_ready); end
    step();
    flush_req = 1'b1; up_valid = 1'b1; up_index = 3'd1; up_tag = 6'h3F; up_vbit = 1'b1;
    #1;
    checks++; if (lk_ready !== 1'b0 || up_ready !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("[TB] FAIL fl_req_cycle got=L%0b/U%0b/we%0b want=0/0/0", lk_ready, up_ready, ram_we); end
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (flush_busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 3'(i) || ram_din !== 7'h0) begin errors++; $display("[TB] FAIL fl_write i=%0d got=b%0b/we%0b/a%0d/d%0h want=b1/we1/a%0d/d0", i, flush_busy, ram_we, ram_addr, ram_din, i); end
      checks++; if (lk_ready !== 1'b0 || up_ready !== 1'b0) begin errors++; $display("[TB] FAIL fl_readys i=%0d got=L%0b/U%0b want=0/0", i, lk_ready, up_ready); end
      if (i == 0) begin
        checks++; if (lk_resp_valid !== 1'b1 || lk_hit !== exp_hit || lk_resp_tag !== exp_tag) begin errors++; $display("[TB] FAIL fl_inflight got=v%0b/h%0b/t%0h want=v1/h%0b/t%0h", lk_resp_valid, lk_hit, lk_resp_tag, exp_hit, exp_tag); end
      end
      model_mem[i] = 7'h0;
      step();
    end
    up_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      lk_valid = (k < 8);
      lk_index = 3'(k);
      lk_tag = 6'($urandom);
      #1;
      if (k == 0) begin
        checks++; if (flush_done !== 1'b1 || flush_busy !== 1'b0) begin errors++; $display("[TB] FAIL fl_done got=d%0b/b%0b want=d1/b0", flush_done, flush_busy); end
      end else if (k == 1) begin
        checks++; if (flush_done !== 1'b0) begin errors++; $display("[TB] FAIL fl_done_pulse got=%0b want=0", flush_done); end
      end
      if (k < 8) begin
        checks++; if (lk_ready !== 1'b1) begin errors++; $display("[TB] FAIL fl_post_ready k=%0d got=%0b want=1", k, lk_ready); end
        eh[k] = model_hit(3'(k), lk_tag);
        et[k] = model_mem[k][5:0];
      end
      if (k >= 2) begin
        checks++; if (lk_resp_valid !== 1'b1 || lk_hit !== eh[k-2] || lk_resp_tag !== et[k-2]) begin errors++; $display("[TB] FAIL fl_post_lookup idx=%0d got=v%0b/h%0b/t%0h want=v1/h%0b/t%0h", k - 2, lk_resp_valid, lk_hit, lk_resp_tag, eh[k-2], et[k-2]); end
      end
      step();
    end
  endtask

  task automatic test_flush_reset();
    logic       eh [8];
    logic [5:0] et [8];
    for (int i = 0; i < 8; i++) begin
      up_valid = 1'b1; up_index = 3'(i); up_tag = 6'($urandom); up_vbit = 1'b1;
      #1;
      checks++; if (up_ready !== 1'b1) begin errors++; $display("[TB] FAIL fr_fill_ready i=%0d got=%0b want=1", i, up_ready); end
      model_mem[i] = {up_vbit, up_tag};
      step();
    end
    up_valid = 1'b0;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      model_mem[i] = 7'h0;
      step();
    end
    reset = 1'b1;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL fr_reset_we got=%0b want=0", ram_we); end
    step();
    reset = 1'b0;
    model_ptr = 1'b0;
    checks++; if (flush_busy !== 1'b0 || flush_done !== 1'b0 || lk_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL fr_after_reset got=b%0b/d%0b/v%0b want=0/0/0", flush_busy, flush_done, lk_resp_valid); end
    for (int k = 0; k < 10; k++) begin
      lk_valid = (k < 8);
      lk_index = 3'(k);
      lk_tag = $urandom_range(0, 1) ? model_mem[k % 8][5:0] : 6'($urandom);
      #1;
      checks++; if (flush_done !== 1'b0) begin errors++; $display("[TB] FAIL fr_no_done k=%0d got=%0b want=0", k, flush_done); end
      if (k < 8) begin
        checks++; if (lk_ready !== 1'b1) begin errors++; $display("[TB] FAIL fr_ready k=%0d got=%0b want=1", k, lk_ready); end
        eh[k] = model_hit(3'(k), lk_tag);
        et[k] = model_mem[k][5:0];
      end
      if (k >= 2) begin
        checks++; if (lk_resp_valid !== 1'b1 || lk_hit !== eh[k-2] || lk_resp_tag !== et[k-2]) begin errors++; $display("[TB] FAIL fr_lookup idx=%0d got=v%0b/h%0b/t%0h want=v1/h%0b/t%0h", k - 2, lk_resp_valid, lk_hit, lk_resp_tag, eh[k-2], et[k-2]); end
      end
      step();
    end
  endtask

  initial begin
    errors = 0; checks = 0; model_ptr = 1'b0;
    reset = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    lk_valid = 1'b0; lk_index = '0; lk_tag = '0;
    up_valid = 1'b0; up_index = '0; up_tag = '0; up_vbit = 1'b0;
    flush_req = 1'b0;
    test_reset();
    test_update_lookup();
    test_contention();
    test_write_after_read();
    test_random();
    test_flush();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
